param_fifo: RTL
===============

# param_fifo

Parametrised synchronous FIFO; the next-generation general-purpose buffer for router input/output ports and NI read/write queues. Configurable data width and depth, valid/ready handshake on both sides, first-word-fall-through read, programmable almost-full/almost-empty flags and sticky overflow/underflow error flags. Single clock domain.

## Interface
Parameters:
- DATA_W, 64, data word width in bits (≥1)
- DEPTH, 32, number of slots; power of two, ≥2
- AW, $clog2(DEPTH), address width; derived, not overridden
- AFULL_TH, DEPTH-2, almost_full asserted when ocup ≥ AFULL_TH
- AEMPTY_TH, 2, almost_empty asserted when ocup ≤ AEMPTY_TH

Ports:
- clk  in  1  clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- wr_valid  in  1  producer offers wr_data
- wr_ready  out  1  FIFO can accept; = ~full
- wr_data  in  DATA_W  write word
- rd_valid  out  1  rd_data holds a valid word; = ~empty
- rd_ready  in  1  consumer takes rd_data this cycle
- rd_data  out  DATA_W  head word; 0 when empty
- full, empty  out  1  ocup == DEPTH / ocup == 0
- almost_full, almost_empty  out  1  threshold flags
- ocup  out  AW+1  current occupancy, 0..DEPTH
- overflow, underflow  out  1  sticky error flags
- clr_err  in  1  synchronous clear of overflow/underflow
- flush  in  1  synchronous empty (only with PARAM_FIFO_FLUSH_EN)

## Operation
- Pointers wr_ptr, rd_ptr are AW+1 bits; low AW bits index storage, MSB is wrap bit. empty: pointers equal. full: low bits equal, MSB differs. ocup = wr_ptr − rd_ptr (mod 2^(AW+1)).
- Push: wr_valid && wr_ready → mem[wr_ptr[AW-1:0]] ← wr_data, wr_ptr+1.
- Pop: rd_valid && rd_ready → rd_ptr+1. rd_data = mem[rd_ptr[AW-1:0]] combinationally (FWFT); forced to 0 when empty.
- Simultaneous push and pop, non-empty non-full: both occur, ocup unchanged.
- Full with pop and wr_valid same cycle: pop occurs, push refused (wr_ready is ~full of current state, no combinational pass-through).
- Empty with push and rd_ready same cycle: push occurs, no pop; no write-to-read bypass.
- overflow set when wr_valid && full; underflow set when rd_ready && empty. Refused request changes no pointer or storage. Flags stay set until clr_err; set condition in the same cycle as clr_err wins (flag stays 1).
- Pointer wrap: natural AW+1-bit rollover; no special handling.
- Storage array not reset; unobservable because rd_data gated by empty.

## Timing
- Reset (reset_n low, asynchronous): pointers 0, overflow/underflow 0. Outputs: empty=1, rd_valid=0, rd_data=0, full=0, wr_ready=1, ocup=0, almost_empty=1, almost_full=0. Deassertion takes effect at next clk edge; reset mid-traffic discards all content immediately.
- Write-to-read latency: 1 cycle; word pushed at edge N visible on rd_data/rd_valid after edge N.
- All status outputs (full, empty, almost_*, ocup, wr_ready, rd_valid) are decoded from registered pointers; updated one edge after the causing transfer.
- Error flags registered: visible the cycle after the offending request.

## Configuration
- PARAM_FIFO_FLUSH_EN defined: flush port present; flush high at an edge sets rd_ptr ← wr_ptr (FIFO empty next cycle); has priority over push and pop in that cycle (both ignored, no error flags set); error flags unaffected.
- Undefined: flush port absent; no flush logic.

## Test plan
- DEPTH=4, DATA_W=8: reset, push 0x11,0x22,0x33,0x44 → full=1, wr_ready=0, ocup=4, rd_data=0x11 throughout.
- Full, wr_valid=1 with 0x55 and rd_ready=1 one cycle → 0x11 popped, 0x55 not stored, overflow=1, ocup=3; clr_err → overflow=0.
- Empty, rd_ready=1 → underflow=1, rd_data=0, pointers unchanged; clr_err and rd_ready together → underflow stays 1.
- Continuous push+pop for 10 words 0x00..0x09 at depth 4 → ocup constant, output sequence 0x00..0x09 in order across pointer wrap.
- AFULL_TH=3, AEMPTY_TH=1: fill 0→4 → almost_empty high at ocup 0,1; almost_full high at ocup 3,4.
- With PARAM_FIFO_FLUSH_EN, ocup=3, flush with wr_valid=1 → next cycle empty=1, ocup=0, overflow/underflow unchanged; assert reset_n=0 mid-stream → all outputs at reset values without clock edge.

Source files
------------

// File: rtl/param_fifo.sv
// param_fifo: parametrised single-clock FIFO with valid/ready handshake on both
// sides, first-word-fall-through read, almost-full/almost-empty thresholds and
// sticky overflow/underflow flags.
//
// Optional feature: define PARAM_FIFO_FLUSH_EN to add the synchronous 'flush'
// port. When it is undefined the port and its logic are absent.
//
// Pointers carry one extra wrap bit, so full and empty can be told apart
// without a separate counter. All status outputs are decoded from the
// registered pointers. There is no write-to-read bypass and no
// pop-to-push pass-through.
module param_fifo #(
    parameter int unsigned  DATA_W    = 64,
    parameter int unsigned  DEPTH     = 32,
    localparam int unsigned AW        = $clog2(DEPTH),
    parameter int unsigned  AFULL_TH  = DEPTH - 2,
    parameter int unsigned  AEMPTY_TH = 2
) (
    input  logic              clk,
    input  logic              reset_n,

    // Producer side
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,

    // Consumer side
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,

    // Status
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [AW:0]       ocup,

    // Sticky error flags
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_err
`ifdef PARAM_FIFO_FLUSH_EN
    ,
    input  logic              flush
`endif
);

    localparam logic [AW:0] PtrOne    = (AW + 1)'(1);
    localparam logic [AW:0] AFullTh   = (AW + 1)'(AFULL_TH);
    localparam logic [AW:0] AEmptyTh  = (AW + 1)'(AEMPTY_TH);

    // Storage is deliberately not reset; rd_data is gated by empty, so stale
    // contents can never be observed.
    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        overflow_q, overflow_d;
    logic        underflow_q, underflow_d;

    logic        push;
    logic        pop;
    logic        ovf_set;
    logic        unf_set;

    logic        full_s;
    logic        empty_s;
    logic [AW:0] ocup_s;

    // Status decode from the registered pointers only.
    always_comb begin
        ocup_s  = wr_ptr_q - rd_ptr_q;
        empty_s = (wr_ptr_q == rd_ptr_q);
        full_s  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    end

    // Transfer decode, next pointers and next error-flag state.
    always_comb begin
        push    = wr_valid && !full_s;
        pop     = rd_ready && !empty_s;
        ovf_set = wr_valid && full_s;
        unf_set = rd_ready && empty_s;
`ifdef PARAM_FIFO_FLUSH_EN
        // Flush overrides both sides and suppresses error detection.
        if (flush) begin
            push    = 1'b0;
            pop     = 1'b0;
            ovf_set = 1'b0;
            unf_set = 1'b0;
        end
`endif
        wr_ptr_d = push ? (wr_ptr_q + PtrOne) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + PtrOne) : rd_ptr_q;
`ifdef PARAM_FIFO_FLUSH_EN
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
        end
`endif
        // A new error in the clearing cycle wins over clr_err.
        overflow_d  = ovf_set || (overflow_q && !clr_err);
        underflow_d = unf_set || (underflow_q && !clr_err);
    end

    // Pointer and error-flag registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage write on an accepted push.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    // Output drive: FWFT head word, zero while empty.
    always_comb begin
        rd_data      = empty_s ? '0 : mem[rd_ptr_q[AW-1:0]];
        rd_valid     = !empty_s;
        wr_ready     = !full_s;
        full         = full_s;
        empty        = empty_s;
        ocup         = ocup_s;
        almost_full  = (ocup_s >= AFullTh);
        almost_empty = (ocup_s <= AEmptyTh);
        overflow     = overflow_q;
        underflow    = underflow_q;
    end

endmodule
